// File: rtl/pingpong_fill_ctrl.sv
// Ping-pong buffer write controller: steers a valid/ready stream into two alternating banks.
// Define PINGPONG_FILL_STATS_EN to add the saturating stall_cnt output.
module pingpong_fill_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        bank_full,
  output logic [ADDR_W:0]   bank_len0,
  output logic [ADDR_W:0]   bank_len1,
  input  logic [1:0]        rd_done
`ifdef PINGPONG_FILL_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic {S_FILL, S_WAIT} ctrl_t;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_t;

  ctrl_t             state, state_nx;
  bank_t             bst [2];
  bank_t             bst_nx [2];
  logic              active, active_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic [1:0]        pend, pend_nx;
  logic [ADDR_W:0]   len [2];
  logic [ADDR_W:0]   len_nx [2];
  logic              hs;
  logic              close;

  assign hs    = in_valid && in_ready;
  assign close = hs && (in_last || (ptr == ADDR_W'(DEPTH - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FILL;
      active  <= 1'b0;
      ptr     <= '0;
      pend    <= '0;
      bst[0]  <= B_EMPTY;
      bst[1]  <= B_EMPTY;
      len[0]  <= '0;
      len[1]  <= '0;
      wr_en   <= 1'b0;
      wr_bank <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_nx;
      active  <= active_nx;
      ptr     <= ptr_nx;
      pend    <= pend_nx;
      bst     <= bst_nx;
      len     <= len_nx;
      wr_en   <= hs;
      if (hs) begin
        wr_bank <= active;
        wr_addr <= ptr;
        wr_data <= in_data;
      end
    end
  end

  // A closed bank sits one cycle in pend (still FILLING) so it turns FULL only after its last write lands.
  always_comb begin
    state_nx  = state;
    active_nx = active;
    ptr_nx    = ptr;
    pend_nx   = '0;
    bst_nx    = bst;
    len_nx    = len;
    for (int b = 0; b < 2; b++) begin
      if (pend[b]) bst_nx[b] = B_FULL;
      if (rd_done[b] && bst[b] == B_FULL) bst_nx[b] = B_EMPTY;
    end
    if (hs) begin
      bst_nx[active] = B_FILLING;
      ptr_nx         = ptr + ADDR_W'(1);
      if (close) begin
        pend_nx[active] = 1'b1;
        len_nx[active]  = {1'b0, ptr} + (ADDR_W + 1)'(1);
        ptr_nx          = '0;
        active_nx       = ~active;
        if (bst_nx[~active] != B_EMPTY) state_nx = S_WAIT;
      end
    end
    if (state == S_WAIT && rd_done[active] && bst[active] == B_FULL) state_nx = S_FILL;
  end

  always_comb begin
    in_ready     = (state == S_FILL) && !rst;
    bank_full[0] = (bst[0] == B_FULL);
    bank_full[1] = (bst[1] == B_FULL);
    bank_len0    = len[0];
    bank_len1    = len[1];
  end

`ifdef PINGPONG_FILL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_fill_ctrl.sv
// Self-checking bench for pingpong_fill_ctrl: directed vector table, corner sequences, random stream vs model.
module tb_pingpong_fill_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        bank_full;
  logic [ADDR_W:0]   bank_len0;
  logic [ADDR_W:0]   bank_len1;
  logic [1:0]        rd_done;
`ifdef PINGPONG_FILL_STATS_EN
  logic [15:0]       stall_cnt;
`endif

  pingpong_fill_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .bank_full(bank_full), .bank_len0(bank_len0),
    .bank_len1(bank_len1), .rd_done(rd_done)
`ifdef PINGPONG_FILL_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;

  // Reference model: a bank is "occupied" from its closing handshake until released;
  // the reader sees it (and may release it) from two cycles after the close.
  int          cyc;
  int          act;
  int          cnt;
  bit          occ [2];
  int          vis [2];
  int          mlen [2];
  bit          m_ready;
  bit          e_en;
  int          e_bank;
  int          e_addr;
  logic [31:0] e_data;
  int          m_stall;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, actual, required, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; act = 0; cnt = 0; m_ready = 1'b1; e_en = 1'b0; m_stall = 0;
    for (int b = 0; b < 2; b++) begin
      occ[b] = 1'b0; vis[b] = 0; mlen[b] = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_wr_bank"}, 64'(wr_bank), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_bank_full"}, 64'(bank_full), 64'd0);
    chk({tag, "_len0"}, 64'(bank_len0), 64'd0);
    chk({tag, "_len1"}, 64'(bank_len1), 64'd0);
`ifdef PINGPONG_FILL_STATS_EN
    chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
`endif
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; rd_done = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic [1:0] rdd);
    bit       hs;
    bit [1:0] efull;
    in_valid = v; in_data = d; in_last = l; rd_done = rdd;
    hs = v && m_ready;
    if (v && !m_ready && m_stall < 65535) m_stall++;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++)
      if (rdd[b] && occ[b] && cyc >= vis[b]) occ[b] = 1'b0;
    e_en = hs;
    if (hs) begin
      e_bank = act; e_addr = cnt; e_data = d;
      cnt++;
      if (l || cnt == DEPTH) begin
        mlen[act] = cnt; occ[act] = 1'b1; vis[act] = cyc + 2; cnt = 0; act = 1 - act;
      end
    end
    m_ready = !occ[act];
    cyc++;
    for (int b = 0; b < 2; b++) efull[b] = occ[b] && cyc >= vis[b];
    chk("wr_en", 64'(wr_en), 64'(e_en));
    if (e_en) begin
      chk("wr_bank", 64'(wr_bank), 64'(e_bank));
      chk("wr_addr", 64'(wr_addr), 64'(e_addr));
      chk("wr_data", 64'(wr_data), 64'(e_data));
    end
    chk("bank_full", 64'(bank_full), 64'(efull));
    if (efull[0]) chk("bank_len0", 64'(bank_len0), 64'(mlen[0]));
    if (efull[1]) chk("bank_len1", 64'(bank_len1), 64'(mlen[1]));
    chk("in_ready", 64'(in_ready), 64'(m_ready));
`ifdef PINGPONG_FILL_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    in_valid = 1'b0; in_last = 1'b0; rd_done = 2'b00;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic [1:0]  rdd;
    logic        e_wr_en;
    logic        e_bank;
    logic [1:0]  e_addr;
    logic [1:0]  e_full;
    logic        e_ready;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 32'h10, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0, 2'b00, 1'b1};
    tbl[1]  = '{1'b1, 32'h11, 1'b0, 2'b00, 1'b1, 1'b0, 2'd1, 2'b00, 1'b1};
    tbl[2]  = '{1'b1, 32'h12, 1'b0, 2'b00, 1'b1, 1'b0, 2'd2, 2'b00, 1'b1};
    tbl[3]  = '{1'b1, 32'h13, 1'b0, 2'b00, 1'b1, 1'b0, 2'd3, 2'b00, 1'b1};
    tbl[4]  = '{1'b1, 32'h14, 1'b0, 2'b00, 1'b1, 1'b1, 2'd0, 2'b01, 1'b1};
    tbl[5]  = '{1'b1, 32'h15, 1'b1, 2'b00, 1'b1, 1'b1, 2'd1, 2'b01, 1'b0};
    tbl[6]  = '{1'b1, 32'h16, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 2'b11, 1'b0};
    tbl[7]  = '{1'b0, 32'h00, 1'b0, 2'b01, 1'b0, 1'b0, 2'd0, 2'b10, 1'b1};
    tbl[8]  = '{1'b1, 32'h17, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 2'b10, 1'b0};
    tbl[9]  = '{1'b0, 32'h00, 1'b0, 2'b10, 1'b0, 1'b0, 2'd0, 2'b01, 1'b1};
    tbl[10] = '{1'b0, 32'h00, 1'b0, 2'b10, 1'b0, 1'b0, 2'd0, 2'b01, 1'b1};
    tbl[11] = '{1'b1, 32'h18, 1'b1, 2'b00, 1'b1, 1'b1, 2'd0, 2'b01, 1'b0};
    tbl[12] = '{1'b0, 32'h00, 1'b0, 2'b01, 1'b0, 1'b0, 2'd0, 2'b10, 1'b1};

    apply_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rdd);
      chk("tbl_wr_en", 64'(wr_en), 64'(tbl[i].e_wr_en));
      if (tbl[i].e_wr_en) begin
        chk("tbl_wr_bank", 64'(wr_bank), 64'(tbl[i].e_bank));
        chk("tbl_wr_addr", 64'(wr_addr), 64'(tbl[i].e_addr));
      end
      chk("tbl_bank_full", 64'(bank_full), 64'(tbl[i].e_full));
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].e_ready));
      if (i == 4) chk("tbl_len0_full", 64'(bank_len0), 64'd4);
    end

    // Release in the window before bank_full rises is ignored
    apply_reset();
    step(1'b1, 32'h20, 1'b1, 2'b00);
    chk("win_full_pre", 64'(bank_full), 64'd0);
    step(1'b0, 32'h0, 1'b0, 2'b01);
    chk("win_full_kept", 64'(bank_full), 64'b01);
    chk("win_len0", 64'(bank_len0), 64'd1);
    step(1'b0, 32'h0, 1'b0, 2'b01);
    chk("win_released", 64'(bank_full), 64'd0);

    // Spurious release of an empty bank
    apply_reset();
    step(1'b0, 32'h0, 1'b0, 2'b10);
    chk("spur_full", 64'(bank_full), 64'd0);
    chk("spur_ready", 64'(in_ready), 64'd1);
    step(1'b1, 32'h21, 1'b0, 2'b00);
    chk("spur_bank", 64'(wr_bank), 64'd0);
    chk("spur_addr", 64'(wr_addr), 64'd0);

    // Back-pressure with both banks full
    apply_reset();
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b1, 32'h30 + 32'(i), 1'b0, 2'b00);
    step(1'b0, 32'h0, 1'b0, 2'b00);
    chk("bp_ready", 64'(in_ready), 64'd0);
    chk("bp_full", 64'(bank_full), 64'b11);
    step(1'b0, 32'h0, 1'b0, 2'b01);
    chk("bp_rel_ready", 64'(in_ready), 64'd1);
    chk("bp_rel_full", 64'(bank_full), 64'b10);
    step(1'b1, 32'h40, 1'b0, 2'b00);
    chk("bp_next_bank", 64'(wr_bank), 64'd0);
    chk("bp_next_addr", 64'(wr_addr), 64'd0);

`ifdef PINGPONG_FILL_STATS_EN
    apply_reset();
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 2'b00);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h60, 1'b0, 2'b00);
    chk("stats_stall10", 64'(stall_cnt), 64'd10);
`endif

    // Asynchronous reset mid-frame
    apply_reset();
    step(1'b1, 32'h70, 1'b0, 2'b00);
    step(1'b1, 32'h71, 1'b0, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(1'b1, 32'h72, 1'b0, 2'b00);
    chk("midrst_wr_en", 64'(wr_en), 64'd1);
    chk("midrst_bank", 64'(wr_bank), 64'd0);
    chk("midrst_addr", 64'(wr_addr), 64'd0);

    // Random stream against the model
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] r;
      r[0] = ($urandom_range(0, 4) == 0);
      r[1] = ($urandom_range(0, 4) == 0);
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 7) == 0, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
